// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order instruction dispatch buffer between the regfile
// stage and the reservation station (RS) / load-store buffer (LSB).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global enable; low freezes all state
//   clr                           misprediction flush
//   in_en, in_* fields            decoded instruction from the regfile stage
//   in_cls                        source class: 0 none, 1 rs1, 2/3 rs1+rs2
//   in_mem                        1 routes to LSB, 0 routes to RS
//   rob_nick_en, rob_nick         ROB tag availability and allocated rd tag
//   cdb_en, cdb_nick, cdb_dt      result broadcast used for operand wakeup
//   rs_rdy, lsb_rdy               destination back-pressure
//   full                          queue holds DEPTH entries
//   dp_rs_en, dp_lsb_en           dispatch strobes, combinational
//   dp_* payload                  head entry, zero when empty or frozen
module dispatch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NICK_W = 4,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IMM_W  = 32,
    parameter int unsigned NAME_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              in_en,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [NAME_W-1:0] in_rd_regnm,
    input  logic              in_pd,
    input  logic [1:0]        in_cls,
    input  logic              in_mem,
    input  logic [NICK_W-1:0] in_rs1_nick,
    input  logic [NICK_W-1:0] in_rs2_nick,
    input  logic [DATA_W-1:0] in_rs1_dt,
    input  logic [DATA_W-1:0] in_rs2_dt,
    input  logic              rob_nick_en,
    input  logic [NICK_W-1:0] rob_nick,
    input  logic              cdb_en,
    input  logic [NICK_W-1:0] cdb_nick,
    input  logic [DATA_W-1:0] cdb_dt,
    input  logic              rs_rdy,
    input  logic              lsb_rdy,
    output logic              full,
    output logic              dp_rs_en,
    output logic              dp_lsb_en,
    output logic [OP_W-1:0]   dp_op,
    output logic [ADDR_W-1:0] dp_pc,
    output logic [IMM_W-1:0]  dp_imm,
    output logic [NAME_W-1:0] dp_rd_regnm,
    output logic              dp_pd,
    output logic [NICK_W-1:0] dp_rd_nick,
    output logic [NICK_W-1:0] dp_rs1_nick,
    output logic [NICK_W-1:0] dp_rs2_nick,
    output logic [DATA_W-1:0] dp_rs1_dt,
    output logic [DATA_W-1:0] dp_rs2_dt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic [NAME_W-1:0] rd_regnm;
        logic              pd;
        logic              mem;
        logic [NICK_W-1:0] rd_nick;
        logic [NICK_W-1:0] rs1_nick;
        logic [NICK_W-1:0] rs2_nick;
        logic [DATA_W-1:0] rs1_dt;
        logic [DATA_W-1:0] rs2_dt;
    } entry_t;

    entry_t            entries_q [DEPTH];
    entry_t            entries_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    entry_t            head_e;
    entry_t            new_e;
    logic              not_empty;
    logic              cdb_live;
    logic              enq;
    logic              deq;

    assign head_e    = entries_q[head_q];
    assign not_empty = (count_q != '0);
    // Tag 0 means "no dependency", so a broadcast of tag 0 never wakes anything.
    assign cdb_live  = cdb_en && (cdb_nick != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign enq       = rdy && !clr && in_en && rob_nick_en && !full;
    assign deq       = dp_rs_en || dp_lsb_en;

    // Dispatch strobes and head payload, with same-cycle CDB forwarding.
    always_comb begin
        dp_rs_en    = 1'b0;
        dp_lsb_en   = 1'b0;
        dp_op       = '0;
        dp_pc       = '0;
        dp_imm      = '0;
        dp_rd_regnm = '0;
        dp_pd       = 1'b0;
        dp_rd_nick  = '0;
        dp_rs1_nick = '0;
        dp_rs2_nick = '0;
        dp_rs1_dt   = '0;
        dp_rs2_dt   = '0;
        if (rdy && not_empty) begin
            dp_rs_en    = !clr && !head_e.mem && rs_rdy;
            dp_lsb_en   = !clr && head_e.mem && lsb_rdy;
            dp_op       = head_e.op;
            dp_pc       = head_e.pc;
            dp_imm      = head_e.imm;
            dp_rd_regnm = head_e.rd_regnm;
            dp_pd       = head_e.pd;
            dp_rd_nick  = head_e.rd_nick;
            dp_rs1_nick = head_e.rs1_nick;
            dp_rs2_nick = head_e.rs2_nick;
            dp_rs1_dt   = head_e.rs1_dt;
            dp_rs2_dt   = head_e.rs2_dt;
            if (cdb_live && head_e.rs1_nick == cdb_nick) begin
                dp_rs1_nick = '0;
                dp_rs1_dt   = cdb_dt;
            end
            if (cdb_live && head_e.rs2_nick == cdb_nick) begin
                dp_rs2_nick = '0;
                dp_rs2_dt   = cdb_dt;
            end
        end
    end

    // Incoming entry: mask unused sources by class, then apply CDB wakeup.
    always_comb begin
        new_e          = '0;
        new_e.op       = in_op;
        new_e.pc       = in_pc;
        new_e.imm      = in_imm;
        new_e.rd_regnm = in_rd_regnm;
        new_e.pd       = in_pd;
        new_e.mem      = in_mem;
        new_e.rd_nick  = rob_nick;
        if (in_cls != 2'd0) begin
            new_e.rs1_nick = in_rs1_nick;
            new_e.rs1_dt   = in_rs1_dt;
        end
        if (in_cls[1]) begin
            new_e.rs2_nick = in_rs2_nick;
            new_e.rs2_dt   = in_rs2_dt;
        end
        if (cdb_live && new_e.rs1_nick == cdb_nick) begin
            new_e.rs1_nick = '0;
            new_e.rs1_dt   = cdb_dt;
        end
        if (cdb_live && new_e.rs2_nick == cdb_nick) begin
            new_e.rs2_nick = '0;
            new_e.rs2_dt   = cdb_dt;
        end
    end

    // Next state: flush beats wakeup/enqueue/dequeue; rdy low holds everything.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (rdy) begin
            if (clr) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_live && entries_q[i].rs1_nick == cdb_nick) begin
                        entries_d[i].rs1_nick = '0;
                        entries_d[i].rs1_dt   = cdb_dt;
                    end
                    if (cdb_live && entries_q[i].rs2_nick == cdb_nick) begin
                        entries_d[i].rs2_nick = '0;
                        entries_d[i].rs2_dt   = cdb_dt;
                    end
                end
                if (enq) begin
                    entries_d[tail_q] = new_e;
                    tail_d            = tail_q + PTR_W'(1);
                end
                if (deq) begin
                    head_d = head_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed stimulus for dispatch_queue with a scoreboard.
// Stimulus pushes the hand-computed dispatch record for each accepted
// instruction; a negedge monitor pops and compares on every dispatch strobe.
module tb_dispatch_queue;

    localparam int unsigned REC_W = 153;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        in_en;
    logic [5:0]  in_op;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rd_regnm;
    logic        in_pd;
    logic [1:0]  in_cls;
    logic        in_mem;
    logic [3:0]  in_rs1_nick;
    logic [3:0]  in_rs2_nick;
    logic [31:0] in_rs1_dt;
    logic [31:0] in_rs2_dt;
    logic        rob_nick_en;
    logic [3:0]  rob_nick;
    logic        cdb_en;
    logic [3:0]  cdb_nick;
    logic [31:0] cdb_dt;
    logic        rs_rdy;
    logic        lsb_rdy;
    logic        full;
    logic        dp_rs_en;
    logic        dp_lsb_en;
    logic [5:0]  dp_op;
    logic [31:0] dp_pc;
    logic [31:0] dp_imm;
    logic [4:0]  dp_rd_regnm;
    logic        dp_pd;
    logic [3:0]  dp_rd_nick;
    logic [3:0]  dp_rs1_nick;
    logic [3:0]  dp_rs2_nick;
    logic [31:0] dp_rs1_dt;
    logic [31:0] dp_rs2_dt;

    logic [REC_W-1:0] exp_q [$];
    logic [REC_W-1:0] act_rec;
    logic [REC_W-1:0] exp_rec;
    int checks;
    int errors;

    dispatch_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .in_en(in_en), .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm),
        .in_rd_regnm(in_rd_regnm), .in_pd(in_pd), .in_cls(in_cls), .in_mem(in_mem),
        .in_rs1_nick(in_rs1_nick), .in_rs2_nick(in_rs2_nick),
        .in_rs1_dt(in_rs1_dt), .in_rs2_dt(in_rs2_dt),
        .rob_nick_en(rob_nick_en), .rob_nick(rob_nick),
        .cdb_en(cdb_en), .cdb_nick(cdb_nick), .cdb_dt(cdb_dt),
        .rs_rdy(rs_rdy), .lsb_rdy(lsb_rdy), .full(full),
        .dp_rs_en(dp_rs_en), .dp_lsb_en(dp_lsb_en), .dp_op(dp_op), .dp_pc(dp_pc),
        .dp_imm(dp_imm), .dp_rd_regnm(dp_rd_regnm), .dp_pd(dp_pd),
        .dp_rd_nick(dp_rd_nick), .dp_rs1_nick(dp_rs1_nick), .dp_rs2_nick(dp_rs2_nick),
        .dp_rs1_dt(dp_rs1_dt), .dp_rs2_dt(dp_rs2_dt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // imm, rd_regnm and pd are derived from pc/op so each entry is distinguishable.
    task automatic set_in(input int op, input int pc, input int cls, input int mem,
                          input int r1n, input int r1d, input int r2n, input int r2d,
                          input int rob);
        in_en       = 1'b1;
        in_op       = 6'(op);
        in_pc       = 32'(pc);
        in_imm      = 32'(pc) ^ 32'hFFFF0000;
        in_rd_regnm = 5'(op);
        in_pd       = 1'(op);
        in_cls      = 2'(cls);
        in_mem      = 1'(mem);
        in_rs1_nick = 4'(r1n);
        in_rs1_dt   = 32'(r1d);
        in_rs2_nick = 4'(r2n);
        in_rs2_dt   = 32'(r2d);
        rob_nick    = 4'(rob);
    endtask

    task automatic push_exp(input int lsb, input int op, input int pc, input int rd,
                            input int r1n, input int r1d, input int r2n, input int r2d);
        exp_q.push_back({1'(lsb), 6'(op), 32'(pc), 32'(pc) ^ 32'hFFFF0000, 5'(op),
                         1'(op), 4'(rd), 4'(r1n), 4'(r2n), 32'(r1d), 32'(r2d)});
    endtask

    // Monitor: every dispatch strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (dp_rs_en || dp_lsb_en) begin
            act_rec = {dp_lsb_en, dp_op, dp_pc, dp_imm, dp_rd_regnm, dp_pd, dp_rd_nick,
                       dp_rs1_nick, dp_rs2_nick, dp_rs1_dt, dp_rs2_dt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch: got %h, required no dispatch", act_rec);
            end else begin
                exp_rec = exp_q.pop_front();
                if (act_rec !== exp_rec || (dp_rs_en && dp_lsb_en)) begin
                    errors++;
                    $display("FAIL dispatch: got %h (rs_en %b), required %h",
                             act_rec, dp_rs_en, exp_rec);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; in_en = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_en = 1'b0; rob_nick_en = 1'b1;
        cdb_en = 1'b0; cdb_nick = '0; cdb_dt = '0;
        rs_rdy = 1'b0; lsb_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_full", 64'(full), 64'd0);
        check("reset_rs_en", 64'(dp_rs_en), 64'd0);
        check("reset_lsb_en", 64'(dp_lsb_en), 64'd0);
        check("reset_pc", 64'(dp_pc), 64'd0);

        // Single rs1-only instruction, dispatch next cycle with rs2 masked.
        rs_rdy = 1'b1;
        set_in(1, 'h100, 1, 0, 0, 5, 2, 9, 3);
        push_exp(0, 1, 'h100, 3, 0, 5, 0, 0);
        tick();
        in_en = 1'b0;
        check("first_rs_en", 64'(dp_rs_en), 64'd1);
        check("first_rd_nick", 64'(dp_rd_nick), 64'd3);
        check("first_rs2_dt", 64'(dp_rs2_dt), 64'd0);
        tick();
        check("first_drained", 64'(dp_rs_en), 64'd0);

        // Fill to full, attempt a fifth, then drain in order across the wrap.
        rs_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(2 + k, 'h200 + 16 * k, 2, 0, 0, 16 * (2 + k), 0, 16 * (2 + k) + 1, 4 + k);
            push_exp(0, 2 + k, 'h200 + 16 * k, 4 + k, 0, 16 * (2 + k), 0, 16 * (2 + k) + 1);
            tick();
        end
        in_en = 1'b0;
        check("full_set", 64'(full), 64'd1);
        set_in(6, 'h240, 2, 0, 0, 0, 0, 0, 8);
        tick();
        check("full_hold", 64'(full), 64'd1);
        rs_rdy = 1'b1;
        tick();
        in_en = 1'b0;
        check("full_clear", 64'(full), 64'd0);
        tick(); tick(); tick();
        check("fill_drained", 64'(dp_rs_en), 64'd0);

        // Stored CDB wakeup, then same-cycle head forwarding.
        rs_rdy = 1'b0;
        set_in(8, 'h300, 2, 0, 0, 1, 6, 'h55, 8);
        push_exp(0, 8, 'h300, 8, 0, 1, 0, 'hDEAD);
        tick();
        in_en = 1'b0;
        cdb_en = 1'b1; cdb_nick = 4'd6; cdb_dt = 32'hDEAD;
        tick();
        cdb_en = 1'b0;
        set_in(9, 'h310, 2, 0, 7, 2, 0, 3, 9);
        push_exp(0, 9, 'h310, 9, 0, 'hBEEF, 0, 3);
        tick();
        in_en = 1'b0;
        check("cdb_stored_nick", 64'(dp_rs2_nick), 64'd0);
        check("cdb_stored_dt", 64'(dp_rs2_dt), 64'hDEAD);
        rs_rdy = 1'b1;
        tick();
        cdb_en = 1'b1; cdb_nick = 4'd7; cdb_dt = 32'hBEEF;
        #1;
        check("cdb_fwd_nick", 64'(dp_rs1_nick), 64'd0);
        check("cdb_fwd_dt", 64'(dp_rs1_dt), 64'hBEEF);
        tick();
        cdb_en = 1'b0; rs_rdy = 1'b0;

        // CDB match on an enqueuing source, and class-0 source masking.
        set_in(10, 'h320, 1, 0, 5, 'h77, 0, 0, 10);
        cdb_en = 1'b1; cdb_nick = 4'd5; cdb_dt = 32'h1234;
        push_exp(0, 10, 'h320, 10, 0, 'h1234, 0, 0);
        tick();
        cdb_en = 1'b0;
        set_in(11, 'h330, 0, 0, 5, 'h88, 3, 'h99, 11);
        push_exp(0, 11, 'h330, 11, 0, 0, 0, 0);
        tick();
        in_en = 1'b0;
        rs_rdy = 1'b1;
        tick(); tick();
        rs_rdy = 1'b0;
        check("cls_drained", 64'(dp_rs_en), 64'd0);

        // Blocked LSB head stalls a ready RS entry behind it.
        rs_rdy = 1'b1; lsb_rdy = 1'b0;
        set_in(12, 'h400, 2, 1, 0, 4, 0, 5, 12);
        push_exp(1, 12, 'h400, 12, 0, 4, 0, 5);
        tick();
        set_in(13, 'h410, 0, 0, 0, 0, 0, 0, 13);
        push_exp(0, 13, 'h410, 13, 0, 0, 0, 0);
        tick();
        in_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_rs_en", 64'(dp_rs_en), 64'd0);
            check("stall_lsb_en", 64'(dp_lsb_en), 64'd0);
            tick();
        end
        lsb_rdy = 1'b1;
        tick(); tick();
        lsb_rdy = 1'b0; rs_rdy = 1'b0;
        check("order_drained", 64'(dp_rs_en), 64'd0);

        // Flush with three queued and a concurrent enqueue.
        for (int k = 0; k < 3; k++) begin
            set_in(14 + k, 'h500 + 16 * k, 2, 0, 0, 0, 0, 0, 1 + k);
            tick();
        end
        set_in(17, 'h530, 2, 0, 0, 0, 0, 0, 4);
        clr = 1'b1; rs_rdy = 1'b1;
        #1;
        check("clr_gate", 64'(dp_rs_en), 64'd0);
        tick();
        clr = 1'b0; in_en = 1'b0;
        #1;
        check("clr_empty_en", 64'(dp_rs_en), 64'd0);
        check("clr_empty_pc", 64'(dp_pc), 64'd0);
        check("clr_full", 64'(full), 64'd0);
        tick(); tick(); tick();
        rs_rdy = 1'b0;

        // No ROB tag: no enqueue. Then rdy low freezes a queued entry.
        rob_nick_en = 1'b0; rs_rdy = 1'b1;
        set_in(18, 'h5F0, 0, 0, 0, 0, 0, 0, 5);
        tick();
        rob_nick_en = 1'b1; in_en = 1'b0;
        #1;
        check("no_rob_tag_en", 64'(dp_rs_en), 64'd0);
        check("no_rob_tag_pc", 64'(dp_pc), 64'd0);
        rs_rdy = 1'b0;
        set_in(19, 'h600, 2, 0, 9, 1, 0, 2, 14);
        push_exp(0, 19, 'h600, 14, 9, 1, 0, 2);
        tick();
        in_en = 1'b0;
        check("queued_head_pc", 64'(dp_pc), 64'h600);
        rdy = 1'b0; rs_rdy = 1'b1;
        cdb_en = 1'b1; cdb_nick = 4'd9; cdb_dt = 32'hAAAA;
        set_in(20, 'h610, 0, 0, 0, 0, 0, 0, 15);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("frozen_en", 64'(dp_rs_en), 64'd0);
            check("frozen_pc", 64'(dp_pc), 64'd0);
            tick();
        end
        rdy = 1'b1; cdb_en = 1'b0; in_en = 1'b0;
        #1;
        check("frozen_nick_kept", 64'(dp_rs1_nick), 64'd9);
        tick();
        rs_rdy = 1'b0;
        check("frozen_drained", 64'(dp_rs_en), 64'd0);

        // Reset mid-operation discards queued entries.
        set_in(21, 'h700, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(22, 'h710, 0, 0, 0, 0, 0, 0, 2);
        tick();
        in_en = 1'b0;
        check("pre_rst_pc", 64'(dp_pc), 64'h700);
        rst = 1'b1;
        tick();
        rst = 1'b0; rs_rdy = 1'b1;
        #1;
        check("rst_mid_en", 64'(dp_rs_en), 64'd0);
        check("rst_mid_full", 64'(full), 64'd0);
        check("rst_mid_pc", 64'(dp_pc), 64'd0);
        tick(); tick(); tick();
        rs_rdy = 1'b0;

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
